// File: rtl/calc_entry_if.sv
// Key-entry / ALU / display signal bundle for calc_entry_controller.
// master: the controller; slave: keypad scanner, ALU and display side.
interface calc_entry_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         key_valid;
    logic [3:0]   key_code;
    logic         alu_done;
    logic         alu_err;
    logic [W-1:0] alu_result;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [1:0]   op;
    logic         alu_start;
    logic         busy;
    logic         error;
    logic [W-1:0] display_value;

    modport master (
        input  key_valid, key_code, alu_done, alu_err, alu_result,
        output operand_a, operand_b, op, alu_start, busy, error, display_value
    );

    modport slave (
        output key_valid, key_code, alu_done, alu_err, alu_result,
        input  operand_a, operand_b, op, alu_start, busy, error, display_value
    );
endinterface

// File: rtl/calc_entry_controller.sv
// Calculator key-entry sequencer: builds operand A, operator, operand B, runs the ALU handshake.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_entry_controller #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic          clock,
    input logic          resetn,
    calc_entry_if.master bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CntFull = CW'(DIGITS);
    localparam logic [3:0] KeyEq  = 4'hE;
    localparam logic [3:0] KeyClr = 4'hF;

    typedef enum logic [2:0] {StEnterA, StEnterB, StExec, StResult, StErr} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;
    logic            start_q, start_d;

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
    logic [TW-1:0]   tmo_q, tmo_d;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    logic            is_digit, is_oper, clr_key;
    logic [3:0]      op_code;

    assign is_digit = bus.key_code < 4'd10;
    assign is_oper  = (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
    assign op_code  = bus.key_code - 4'd10;
    // Clear is honoured everywhere except while the ALU owns the operands.
    assign clr_key  = bus.key_valid && (bus.key_code == KeyClr) && (state_q != StExec);

    function automatic logic [W-1:0] append(input logic [W-1:0] v, input logic [3:0] d);
        return {v[W-5:0], d};
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        start_d = 1'b0;
`ifdef CALC_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            StEnterA: begin
                if (bus.key_valid && is_digit && cnt_a_q < CntFull) begin
                    a_d     = append(a_q, bus.key_code);
                    cnt_a_d = cnt_a_q + 1'b1;
                end else if (bus.key_valid && is_oper) begin
                    op_d    = op_code[1:0];
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = StEnterB;
                end
            end
            StEnterB: begin
                if (bus.key_valid && is_digit && cnt_b_q < CntFull) begin
                    b_d     = append(b_q, bus.key_code);
                    cnt_b_d = cnt_b_q + 1'b1;
                end else if (bus.key_valid && is_oper && cnt_b_q == '0) begin
                    op_d = op_code[1:0];
                end else if (bus.key_valid && bus.key_code == KeyEq && cnt_b_q != '0) begin
                    start_d = 1'b1;
                    state_d = StExec;
`ifdef CALC_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            StExec: begin
                if (bus.alu_done) begin
                    if (bus.alu_err) begin
                        state_d = StErr;
                    end else begin
                        a_d     = bus.alu_result;
                        cnt_a_d = CntFull;
                        state_d = StResult;
                    end
                end
`ifdef CALC_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            StResult: begin
                if (bus.key_valid && is_digit) begin
                    a_d     = {{(W-4){1'b0}}, bus.key_code};
                    cnt_a_d = CW'(1);
                    state_d = StEnterA;
                end else if (bus.key_valid && is_oper) begin
                    op_d    = op_code[1:0];
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = StEnterB;
                end
            end
            StErr: ;
            default: state_d = StEnterA;
        endcase

        if (clr_key) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'd0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = StEnterA;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StEnterA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'd0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            start_q <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            start_q <= start_d;
`ifdef CALC_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        bus.display_value = a_q;
        unique case (state_q)
            StEnterB: bus.display_value = (cnt_b_q == '0) ? a_q : b_q;
            StErr:    bus.display_value = {DIGITS{4'hE}};
            default:  bus.display_value = a_q;
        endcase
    end

    assign bus.operand_a = a_q;
    assign bus.operand_b = b_q;
    assign bus.op        = op_q;
    assign bus.alu_start = start_q;
    assign bus.busy      = (state_q == StExec);
    assign bus.error     = (state_q == StErr);
endmodule

// File: tb/tb_calc_entry_controller.sv
// Bench for calc_entry_controller: directed scenarios then random keys/ALU replies vs a model.
module tb_calc_entry_controller;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W = 4 * DIGITS;
`ifdef CALC_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1000;
`endif
    localparam int ModeA = 0, ModeB = 1, ModeExec = 2, ModeRes = 3, ModeErr = 4;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    calc_entry_if #(.DIGITS(DIGITS)) bus ();
    calc_entry_controller #(.DIGITS(DIGITS), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: plain values and digit counts.
    int           m_mode;
    logic [W-1:0] m_a, m_b;
    int           m_na, m_nb, m_op, m_exec_cyc;
    bit           m_start;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode = ModeA; m_a = '0; m_b = '0; m_na = 0; m_nb = 0; m_op = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_start = 0; m_exec_cyc = 0;
    endtask

    task automatic model_update(input bit kv, input int kc, input bit done, input bit err,
                                input logic [W-1:0] res);
        m_start = 0;
        if (m_mode == ModeExec) begin
            m_exec_cyc++;
            if (done) begin
                if (err) m_mode = ModeErr;
                else begin m_a = res; m_na = DIGITS; m_mode = ModeRes; end
            end
`ifdef CALC_TIMEOUT_EN
            else if (m_exec_cyc >= TMO) m_mode = ModeErr;
`endif
        end else if (kv) begin
            if (kc == 15) model_clear();
            else if (m_mode == ModeErr) ;
            else if (kc < 10) begin
                if (m_mode == ModeA && m_na < DIGITS) begin m_a = m_a * 16 + W'(kc); m_na++; end
                else if (m_mode == ModeB && m_nb < DIGITS) begin m_b = m_b * 16 + W'(kc); m_nb++; end
                else if (m_mode == ModeRes) begin m_a = W'(kc); m_na = 1; m_mode = ModeA; end
            end else if (kc < 14) begin
                if (m_mode == ModeA || m_mode == ModeRes) begin
                    m_op = kc - 10; m_b = '0; m_nb = 0; m_mode = ModeB;
                end else if (m_mode == ModeB && m_nb == 0) m_op = kc - 10;
            end else if (m_mode == ModeB && m_nb > 0) begin
                m_start = 1; m_mode = ModeExec; m_exec_cyc = 0;
            end
        end
    endtask

    function automatic logic [W-1:0] model_display();
        if (m_mode == ModeErr) return {DIGITS{4'hE}};
        if (m_mode == ModeB && m_nb > 0) return m_b;
        return m_a;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".a"}, 64'(bus.operand_a), 64'(m_a));
        check_eq({tag, ".b"}, 64'(bus.operand_b), 64'(m_b));
        check_eq({tag, ".op"}, 64'(bus.op), 64'(m_op));
        check_eq({tag, ".start"}, 64'(bus.alu_start), 64'(m_start));
        check_eq({tag, ".busy"}, 64'(bus.busy), 64'(m_mode == ModeExec));
        check_eq({tag, ".error"}, 64'(bus.error), 64'(m_mode == ModeErr));
        check_eq({tag, ".disp"}, 64'(bus.display_value), 64'(model_display()));
    endtask

    // One clock: drive inputs, let the edge happen, check #1 later.
    task automatic step(input string tag, input bit kv, input logic [3:0] kc, input bit done,
                        input bit err, input logic [W-1:0] res);
        bus.key_valid = kv; bus.key_code = kc;
        bus.alu_done = done; bus.alu_err = err; bus.alu_result = res;
        @(posedge clock);
        model_update(kv, int'(kc), done, err, res);
        #1;
        check_all(tag);
    endtask

    task automatic keys(input string tag, input logic [3:0] k[$]);
        foreach (k[i]) step(tag, 1'b1, k[i], 1'b0, 1'b0, '0);
    endtask

    initial begin
        bus.key_valid = 0; bus.key_code = 0; bus.alu_done = 0; bus.alu_err = 0;
        bus.alu_result = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        resetn = 1'b1;

        // 12 + 3 with ALU answering in the alu_start cycle
        keys("add", '{4'h1, 4'h2, 4'hA, 4'h3, 4'hE});
        check_eq("add.start", 64'(bus.alu_start), 64'h1);
        check_eq("add.opa", 64'(bus.operand_a), 64'h12);
        check_eq("add.opb", 64'(bus.operand_b), 64'h3);
        step("add_done", 1'b1, 4'h7, 1'b1, 1'b0, 16'h0015);
        check_eq("add.disp", 64'(bus.display_value), 64'h15);
        check_eq("add.busy", 64'(bus.busy), 64'h0);

        // Chain on result; F during EXEC dropped
        keys("chain", '{4'hC, 4'h2, 4'hE, 4'hF});
        check_eq("chain.busy", 64'(bus.busy), 64'h1);
        check_eq("chain.opa", 64'(bus.operand_a), 64'h15);
        check_eq("chain.op", 64'(bus.op), 64'h2);
        step("chain_done", 1'b0, 4'h0, 1'b1, 1'b0, 16'h002A);

        keys("five", '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
        check_eq("five.disp", 64'(bus.display_value), 64'h1234);

        keys("oprep", '{4'hF, 4'h7, 4'hA, 4'hB, 4'h2, 4'hA});
        check_eq("oprep.op", 64'(bus.op), 64'h1);
        check_eq("oprep.b", 64'(bus.operand_b), 64'h2);

        keys("div0", '{4'hF, 4'h8, 4'hD, 4'h0, 4'hE});
        step("div0_done", 1'b0, 4'h0, 1'b1, 1'b1, '0);
        check_eq("div0.err", 64'(bus.error), 64'h1);
        check_eq("div0.disp", 64'(bus.display_value), 64'hEEEE);
        keys("div0_dig", '{4'h5, 4'hE, 4'hA});
        keys("div0_clr", '{4'hF});
        check_eq("div0.clr", 64'(bus.display_value), 64'h0);

        // Stray alu_done outside EXEC must be ignored
        step("stray", 1'b0, 4'h0, 1'b1, 1'b0, 16'hBEEF);

        // Reset in the alu_start cycle
        keys("rst", '{4'h1, 4'hA, 4'h2, 4'hE});
        bus.key_valid = 0; bus.alu_done = 0;
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check_eq("rst.start", 64'(bus.alu_start), 64'h0);
        check_eq("rst.busy", 64'(bus.busy), 64'h0);
        check_eq("rst.a", 64'(bus.operand_a), 64'h0);
        @(negedge clock);
        resetn = 1'b1;
        step("rst_late_done", 1'b0, 4'h0, 1'b1, 1'b0, 16'h5555);

        // Watchdog behaviour
        keys("tmo", '{4'h1, 4'hA, 4'h1, 4'hE});
`ifdef CALC_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) step("tmo_wait", 1'b0, 4'h0, 1'b0, 1'b0, '0);
        check_eq("tmo.busy", 64'(bus.busy), 64'h1);
        step("tmo_exp", 1'b0, 4'h0, 1'b0, 1'b0, '0);
        check_eq("tmo.err", 64'(bus.error), 64'h1);
        keys("tmo_clr", '{4'hF});
`else
        for (int i = 0; i < 100; i++) step("tmo_wait", 1'b0, 4'h0, 1'b0, 1'b0, '0);
        check_eq("tmo.busy", 64'(bus.busy), 64'h1);
        step("tmo_done", 1'b0, 4'h0, 1'b1, 1'b0, 16'h0002);
`endif

        // Random keys and ALU replies
        for (int i = 0; i < 4000; i++) begin
            step("rand", ($urandom_range(0, 9) < 6), 4'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_entry_controller.md
# calc_entry_controller

Sequences calculator key entry between the debounced keypad scanner and the arithmetic unit. Consumes single-cycle key strobes with 4-bit hex keycodes, accumulates operand A, operator and operand B, then issues a start/done handshake to the ALU and holds the result for display and chaining. Sits directly downstream of the keypad scanner and upstream of the ALU and 7-segment display driver.

## Interface
- DIGITS, 4: max hex digits per operand; W = 4*DIGITS.
- TIMEOUT, 1000: ALU watchdog limit in clock cycles (used only with CALC_TIMEOUT_EN).
- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle key strobe from scanner.
- key_code  in  4  0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
- alu_done  in  1  one-cycle completion pulse.
- alu_err  in  1  qualifies alu_done (divide by zero, overflow).
- alu_result  in  W  result, valid when alu_done=1.
- operand_a  out  W  operand A register.
- operand_b  out  W  operand B register.
- op  out  2  operator (0 add, 1 sub, 2 mul, 3 div).
- alu_start  out  1  one-cycle start pulse.
- busy  out  1  high in EXEC.
- error  out  1  high in ERR.
- display_value  out  W  value for display.

## Operation
- States: ENTER_A, ENTER_B, EXEC, RESULT, ERR. Reset -> ENTER_A, all outputs 0, digit counts 0.
- Digit append: reg <= {reg[W-5:0], code}, count+1; digits beyond DIGITS ignored (no wrap, no error).
- Key F (clear), any state except EXEC: A=B=0, op=0, counts 0 -> ENTER_A.
- ENTER_A: digit appends to A. Operator latches op, B=0, count_b=0 -> ENTER_B. E ignored.
- ENTER_B: digit appends to B. Operator with count_b=0 replaces op; with count_b>0 ignored. E with count_b=0 ignored; else pulse alu_start -> EXEC.
- EXEC: all keys (including F) dropped. alu_done & !alu_err: A <= alu_result, count_a=DIGITS -> RESULT. alu_done & alu_err -> ERR.
- RESULT: digit -> A=digit, count_a=1 -> ENTER_A. Operator -> op latched, B=0, count_b=0 -> ENTER_B (chaining on result). E ignored.
- ERR: only F exits.
- display_value: ENTER_A/RESULT -> A; ENTER_B -> (count_b=0 ? A : B); EXEC -> A; ERR -> all nibbles 4'hE.

## Timing
- key_valid sampled on rising edge; registers, state and display_value update on that edge (visible 1 cycle after strobe).
- alu_start registered, high exactly the cycle after E is sampled; busy rises on the same edge.
- operand_a, operand_b, op stable from alu_start until EXEC is exited.
- alu_done accepted in EXEC, including the alu_start cycle itself (combinational ALU); ignored in every other state.
- key_valid coincident with alu_done: key dropped; result captured.
- Reset asserted mid-EXEC: immediate return to reset values; a later alu_done ignored.
- No back-to-back key limit: consecutive-cycle strobes each processed.

## Configuration
- CALC_TIMEOUT_EN defined: cycle counter cleared on EXEC entry; if TIMEOUT cycles elapse in EXEC without alu_done -> ERR; alu_done arriving on the expiry cycle wins.
- Undefined: no counter; EXEC waits indefinitely for alu_done.

## Test plan
- Keys 1,2,A,3,E; ALU returns 0x0015 one cycle later -> alu_start one pulse with A=0x0012, B=0x0003, op=0; RESULT, display 0x0015.
- Keys 1,2,3,4,5 -> A=0x1234, fifth digit ignored, display 0x1234.
- Keys 7,A,B,2 -> op=1 (replacement), B=0x0002; then A after digit -> op stays 1.
- Keys 8,D,0,E; alu_done with alu_err=1 -> ERR, error=1, display 0xEEEE; digit ignored; F -> ENTER_A, all 0.
- From RESULT 0x0015: keys C,2,E -> operand_a=0x0015, op=2, B=0x0002; F during EXEC dropped.
- CALC_TIMEOUT_EN, TIMEOUT=8: no alu_done -> ERR 8 cycles after EXEC entry; without macro, busy stays high for 100 cycles.
